// File: rtl/ram_pkg.sv
// Shared definitions for the platform-independent RAM library: collision-mode
// selectors and the state type of the reset-time clear sequencer.
package ram_pkg;

    // Behaviour of a read that hits the address being written on the same edge.
    localparam int RD_FIRST = 0;  // read returns the word as it was before the write
    localparam int WR_FIRST = 1;  // read returns the written lanes merged over the old word

    // Clear sequencer states.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

endpackage : ram_pkg

// File: rtl/ram_clear_seq.sv
// Reset-time clear sequencer: after reset deassertion it walks every address
// once, requesting an all-zero write per cycle, then parks in READY. The
// owning RAM muxes clr_we/clr_addr into its write port while init_busy is high.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int Depth        = 64,
    parameter int ClearOnReset = 1,
    parameter int AddrWidth    = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 init_busy,
    output logic                 clr_we,
    output logic [AddrWidth-1:0] clr_addr
);

    localparam logic [AddrWidth-1:0] LastAddr   = AddrWidth'(Depth - 1);
    localparam clr_state_e           ResetState = (ClearOnReset != 0) ? CLEAR : READY;

    clr_state_e           state_q, state_d;
    logic [AddrWidth-1:0] cnt_q, cnt_d;

    // State and address counter; a reset mid-clear restarts the walk at address 0.
    // NOTE: clocked state is assigned with <= so every register samples the
    // pre-edge values; = here would make the result depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ResetState;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: one zero write per cycle until the last address is written.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AddrWidth'(1);
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    assign init_busy = (state_q == CLEAR);
    assign clr_addr  = cnt_q;

endmodule : ram_clear_seq

// File: rtl/ram_1c_1r_1w_be.sv
// Single-clock simple dual-port RAM: one byte-enabled write port, one read port
// with a rd_en/rd_valid pair, 1 or 2 cycles of read latency, deterministic
// same-address collision handling and an optional zero-fill after reset.
module ram_1c_1r_1w_be
    import ram_pkg::*;
#(
    parameter int Width         = 18,
    parameter int ByteWidth     = 9,
    parameter int Depth         = 64,
    parameter int ReadLatency   = 1,
    parameter int CollisionMode = RD_FIRST,
    parameter int ClearOnReset  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       init_busy,
    input  logic                       wr_en,
    input  logic [$clog2(Depth)-1:0]   wr_addr,
    input  logic [Width/ByteWidth-1:0] wr_be,
    input  logic [Width-1:0]           wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(Depth)-1:0]   rd_addr,
    output logic                       rd_valid,
    output logic [Width-1:0]           rd_data
);

    localparam int                 NumBytes  = Width / ByteWidth;
    localparam int                 AddrWidth = $clog2(Depth);
    localparam logic [AddrWidth:0] DepthW    = (AddrWidth + 1)'(Depth);

    // Parameter legality checks at elaboration.
    if (Width % ByteWidth != 0) begin : g_bad_width
        $error("ram_1c_1r_1w_be: Width (%0d) is not a multiple of ByteWidth (%0d)", Width, ByteWidth);
    end
    if (ReadLatency != 1 && ReadLatency != 2) begin : g_bad_latency
        $error("ram_1c_1r_1w_be: ReadLatency must be 1 or 2, got %0d", ReadLatency);
    end
    if (Depth < 2) begin : g_bad_depth
        $error("ram_1c_1r_1w_be: Depth must be at least 2, got %0d", Depth);
    end

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    logic                 clr_we;
    logic [AddrWidth-1:0] clr_addr;

    ram_clear_seq #(
        .Depth        (Depth),
        .ClearOnReset (ClearOnReset),
        .AddrWidth    (AddrWidth)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // ------------------------------------------------------------------
    // Port qualification: user requests are masked during the clear and
    // out-of-range addresses never reach the array.
    // ------------------------------------------------------------------
    logic wr_in_range, rd_in_range;
    logic wr_ok, rd_fire, collide;

    assign wr_in_range = ({1'b0, wr_addr} < DepthW);
    assign rd_in_range = ({1'b0, rd_addr} < DepthW);
    assign wr_ok       = wr_en && !init_busy && wr_in_range;
    assign rd_fire     = rd_en && !init_busy;
    assign collide     = (CollisionMode == WR_FIRST) && rd_fire && wr_ok && (rd_addr == wr_addr);

    logic                 mem_we;
    logic [AddrWidth-1:0] mem_addr;
    logic [NumBytes-1:0]  mem_be;
    logic [Width-1:0]     mem_wdata;

    assign mem_we    = init_busy ? clr_we   : wr_ok;
    assign mem_addr  = init_busy ? clr_addr : wr_addr;
    assign mem_be    = init_busy ? '1       : wr_be;
    assign mem_wdata = init_busy ? '0       : wr_data;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [Width-1:0] mem [Depth];

    // Byte-lane write into the array.
    // NOTE: the array deliberately has no reset; a reset on storage prevents
    // block-RAM inference. Zeroing is the clear sequencer's job.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][i*ByteWidth +: ByteWidth] <= mem_wdata[i*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1: array read (old data on a collision) plus the write
    // lanes to forward when write-first collision handling applies.
    // ------------------------------------------------------------------
    logic                s1_valid;
    logic [Width-1:0]    s1_raw;
    logic [NumBytes-1:0] s1_fwd_be;
    logic [Width-1:0]    s1_fwd_data;
    logic [Width-1:0]    s1_data;

    // Stage-1 registers load only on an accepted read so the output holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_raw      <= '0;
            s1_fwd_be   <= '0;
            s1_fwd_data <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_raw      <= rd_in_range ? mem[rd_addr] : '0;
                s1_fwd_be   <= collide ? wr_be : '0;
                s1_fwd_data <= wr_data;
            end
        end
    end

    // Collision bypass: replace the old lanes that the same-edge write covered.
    always_comb begin
        s1_data = s1_raw;
        for (int i = 0; i < NumBytes; i++) begin
            if (s1_fwd_be[i]) begin
                s1_data[i*ByteWidth +: ByteWidth] = s1_fwd_data[i*ByteWidth +: ByteWidth];
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------
    if (ReadLatency == 2) begin : g_lat2
        logic             s2_valid;
        logic [Width-1:0] s2_data;

        // Output register; valid travels with the data and the data holds when idle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
    end else begin : g_lat1
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
    end

    // Simulation warnings for out-of-range accesses (writes dropped, reads return 0).
    always_ff @(posedge clk) begin
        if (rst_n && !init_busy && wr_en) begin
            assert (wr_in_range)
            else $warning("ram_1c_1r_1w_be: write to address %0d beyond depth %0d dropped", wr_addr, Depth);
        end
        if (rst_n && !init_busy && rd_en) begin
            assert (rd_in_range)
            else $warning("ram_1c_1r_1w_be: read of address %0d beyond depth %0d returns zero", rd_addr, Depth);
        end
    end

endmodule : ram_1c_1r_1w_be

// File: tb/tb_ram_1c_1r_1w_be.sv
// Directed bench for ram_1c_1r_1w_be. Three instances share one stimulus stream:
//   u_d0: Depth 64, latency 1, read-first
//   u_d1: Depth 64, latency 2, write-first
//   u_d2: Depth 48, latency 1, read-first (out-of-range addresses exist)
module tb_ram_1c_1r_1w_be;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [1:0]  wr_be = '0;
    logic [17:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [5:0]  rd_addr = '0;

    logic        busy0, busy1, busy2;
    logic        v0, v1, v2;
    logic [17:0] d0, d1, d2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_1c_1r_1w_be #(
        .Width(18), .ByteWidth(9), .Depth(64), .ReadLatency(1), .CollisionMode(0), .ClearOnReset(1)
    ) u_d0 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(v0), .rd_data(d0)
    );

    ram_1c_1r_1w_be #(
        .Width(18), .ByteWidth(9), .Depth(64), .ReadLatency(2), .CollisionMode(1), .ClearOnReset(1)
    ) u_d1 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(v1), .rd_data(d1)
    );

    ram_1c_1r_1w_be #(
        .Width(18), .ByteWidth(9), .Depth(48), .ReadLatency(1), .CollisionMode(0), .ClearOnReset(1)
    ) u_d2 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(v2), .rd_data(d2)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge and sample 1 ns after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [17:0] d, input logic [1:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
    endtask

    task automatic rd(input logic [5:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
    endtask

    initial begin
        int n;
        int n2;
        logic valid_seen;

        // ---------------- reset state ----------------
        idle();
        repeat (3) cycle();
        check("rst_busy0", busy0, 1);
        check("rst_busy1", busy1, 1);
        check("rst_busy2", busy2, 1);
        check("rst_valid0", v0, 0);
        check("rst_data0", d0, 0);
        check("rst_valid1", v1, 0);
        check("rst_data1", d1, 0);

        // ---------------- clear duration ----------------
        rst_n = 1'b1;
        n  = 0;
        n2 = 0;
        while ((busy0 || busy2) && n < 200) begin
            cycle();
            n++;
            if (!busy2 && n2 == 0) n2 = n;
        end
        check("clear_cycles_d64", n, 64);
        check("clear_cycles_d48", n2, 48);
        check("clear_busy1_done", busy1, 0);

        // Read of the last address right after the clear: zero.
        rd(6'd63);
        cycle();
        idle();
        check("rd63_valid0", v0, 1);
        check("rd63_data0", d0, 18'h00000);
        check("rd63_valid1_early", v1, 0);
        check("rd63_valid2_oob", v2, 1);
        check("rd63_data2_oob", d2, 18'h00000);
        cycle();
        check("rd63_valid0_pulse", v0, 0);
        check("rd63_valid1", v1, 1);
        check("rd63_data1", d1, 18'h00000);

        // ---------------- byte enables ----------------
        // Lane 0 is bits [8:0]; clearing it in 0x3FFFF leaves 0x3FE00.
        wr(6'd5, 18'h3FFFF, 2'b11);
        cycle();
        wr(6'd5, 18'h00000, 2'b01);
        cycle();
        idle();
        rd(6'd5);
        cycle();
        idle();
        check("be_data0", d0, 18'h3FE00);
        check("be_data2", d2, 18'h3FE00);
        cycle();
        check("be_data1", d1, 18'h3FE00);

        // ---------------- collisions, full word ----------------
        wr(6'd7, 18'h0AAAA, 2'b11);
        cycle();
        wr(6'd7, 18'h12345, 2'b11);
        rd(6'd7);
        cycle();
        idle();
        check("coll_rdfirst_d0", d0, 18'h0AAAA);
        check("coll_rdfirst_d2", d2, 18'h0AAAA);
        cycle();
        check("coll_wrfirst_d1", d1, 18'h12345);

        // ---------------- collisions, lane 0 only ----------------
        // Old 0x0AAAA: lane1 = 0x055, new 0x12345: lane0 = 0x145 -> 0x0AB45.
        wr(6'd7, 18'h0AAAA, 2'b11);
        cycle();
        wr(6'd7, 18'h12345, 2'b01);
        rd(6'd7);
        cycle();
        idle();
        check("coll_be01_rdfirst_d0", d0, 18'h0AAAA);
        cycle();
        check("coll_be01_wrfirst_d1", d1, 18'h0AB45);
        rd(6'd7);
        cycle();
        idle();
        check("coll_be01_stored_d0", d0, 18'h0AB45);
        cycle();
        check("coll_be01_stored_d1", d1, 18'h0AB45);

        // ---------------- write on the edge after a read ----------------
        rd(6'd9);
        cycle();
        idle();
        check("raw_next_d0", d0, 18'h00000);
        wr(6'd9, 18'h11111, 2'b11);
        cycle();
        idle();
        check("raw_next_valid1", v1, 1);
        check("raw_next_d1", d1, 18'h00000);
        rd(6'd9);
        cycle();
        idle();
        check("raw_after_d0", d0, 18'h11111);

        // ---------------- streaming reads, latency 2 ----------------
        wr(6'd0, 18'h00101, 2'b11);
        cycle();
        wr(6'd1, 18'h00202, 2'b11);
        cycle();
        wr(6'd2, 18'h00303, 2'b11);
        cycle();
        idle();
        rd(6'd0);
        cycle();
        check("stream_a_v0", v0, 1);
        check("stream_a_d0", d0, 18'h00101);
        check("stream_a_v1", v1, 0);
        rd(6'd1);
        cycle();
        check("stream_b_v1", v1, 1);
        check("stream_b_d1", d1, 18'h00101);
        check("stream_b_d0", d0, 18'h00202);
        rd(6'd2);
        cycle();
        idle();
        check("stream_c_v1", v1, 1);
        check("stream_c_d1", d1, 18'h00202);
        cycle();
        check("stream_d_v1", v1, 1);
        check("stream_d_d1", d1, 18'h00303);
        check("stream_d_v0", v0, 0);
        check("stream_d_hold_d0", d0, 18'h00303);
        cycle();
        check("stream_e_v1", v1, 0);
        check("stream_e_hold_d1", d1, 18'h00303);

        // ---------------- out of range (Depth 48) ----------------
        wr(6'd50, 18'h3FFFF, 2'b11);
        cycle();
        idle();
        rd(6'd50);
        cycle();
        idle();
        check("oob_valid2", v2, 1);
        check("oob_data2", d2, 18'h00000);
        check("oob_inrange_d0", d0, 18'h3FFFF);
        rd(6'd2);
        cycle();
        idle();
        check("oob_no_alias_d2", d2, 18'h00303);

        // ---------------- asynchronous reset, then reset mid-clear ----------------
        rd(6'd2);
        cycle();
        idle();
        check("pre_rst_valid0", v0, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid0", v0, 0);
        check("async_rst_data0", d0, 0);
        check("async_rst_busy0", busy0, 1);
        cycle();
        rst_n = 1'b1;
        repeat (30) cycle();
        rst_n = 1'b0;
        #1;
        check("midclr_rst_valid0", v0, 0);
        cycle();
        rst_n = 1'b1;
        wr(6'd5, 18'h12345, 2'b11);
        rd(6'd5);
        n = 0;
        valid_seen = 1'b0;
        while (busy0 && n < 200) begin
            cycle();
            n++;
            valid_seen = valid_seen | v0 | v1;
        end
        idle();
        check("restart_clear_cycles", n, 64);
        check("restart_no_valid", valid_seen, 0);
        rd(6'd5);
        cycle();
        idle();
        check("restart_wr_ignored_v0", v0, 1);
        check("restart_wr_ignored_d0", d0, 18'h00000);
        cycle();
        check("restart_wr_ignored_d1", d1, 18'h00000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ram_1c_1r_1w_be
